// File: rtl/alu_sequencer.sv
// Control-side driver for the 16-bit combinational ALU: request/response handshakes,
// opcode-to-control encoding, and an optional multi-cycle multiply (`ALU_SEQ_MUL_EN).
module alu_sequencer #(
    parameter int W   = 16,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [OPW-1:0] req_op,
    input  logic [W-1:0]   req_a,
    input  logic [W-1:0]   req_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_cf,
    output logic           rsp_sf,
    output logic           rsp_zf,
    output logic           rsp_err,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic           alu_ci,
    output logic           alu_nb,
    output logic           alu_ic,
    output logic           alu_na,
    output logic           alu_xo,
    output logic           alu_no,
    output logic           alu_sr,
    output logic           alu_ss,
    input  logic [W-1:0]   alu_out,
    input  logic           alu_cf,
    input  logic           alu_sf,
    input  logic           alu_zf
);

    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_XOR = OPW'(2);
    localparam logic [OPW-1:0] OP_INC = OPW'(3);
    localparam logic [OPW-1:0] OP_DEC = OPW'(4);
    localparam logic [OPW-1:0] OP_NOT = OPW'(5);
    localparam logic [OPW-1:0] OP_NEG = OPW'(6);
    localparam logic [OPW-1:0] OP_OR  = OPW'(7);
    localparam logic [OPW-1:0] OP_AND = OPW'(8);
    localparam logic [OPW-1:0] OP_SHL = OPW'(9);
    localparam logic [OPW-1:0] OP_SHR = OPW'(10);
    localparam logic [OPW-1:0] OP_SAR = OPW'(11);
`ifdef ALU_SEQ_MUL_EN
    localparam logic [OPW-1:0] OP_MUL = OPW'(12);
`endif

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [2:0] {IDLE, EXEC, MUL_ADD, MUL_DBL, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, EXEC, RESP} state_t;
`endif

    typedef struct packed {
        logic ci;
        logic nb;
        logic ic;
        logic na;
        logic xo;
        logic no;
        logic sr;
        logic ss;
    } ctl_t;

    typedef enum logic [1:0] {B_REG, B_ZERO, B_A} bsel_t;

    typedef struct packed {
        ctl_t  ctl;
        bsel_t bsel;
        logic  legal;
    } dec_t;

    function automatic dec_t decode(input logic [OPW-1:0] op);
        dec_t d;
        d.ctl   = '0;
        d.bsel  = B_REG;
        d.legal = 1'b1;
        case (op)
            OP_ADD: ;
            OP_SUB: begin d.ctl.ci = 1'b1; d.ctl.nb = 1'b1; end
            OP_XOR: d.ctl.ic = 1'b1;
            OP_INC: begin d.bsel = B_ZERO; d.ctl.ci = 1'b1; end
            OP_DEC: begin d.bsel = B_ZERO; d.ctl.nb = 1'b1; end
            OP_NOT: begin d.bsel = B_ZERO; d.ctl.nb = 1'b1; d.ctl.ic = 1'b1; end
            OP_NEG: begin d.bsel = B_ZERO; d.ctl.ci = 1'b1; d.ctl.na = 1'b1; end
            OP_OR:  begin d.ctl.ic = 1'b1; d.ctl.xo = 1'b1; end
            OP_AND: begin
                d.ctl.ic = 1'b1; d.ctl.na = 1'b1; d.ctl.nb = 1'b1;
                d.ctl.no = 1'b1; d.ctl.xo = 1'b1;
            end
            OP_SHL: d.bsel = B_A;
            OP_SHR: begin d.bsel = B_ZERO; d.ctl.sr = 1'b1; end
            OP_SAR: begin d.bsel = B_ZERO; d.ctl.sr = 1'b1; d.ctl.ss = 1'b1; end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: ;
`endif
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q;
    logic [W-1:0]   a_q, b_q;
    logic           err_q;
    dec_t           dec;
    ctl_t           ctl;
    logic           accept;

`ifdef ALU_SEQ_MUL_EN
    logic [W-1:0]   acc_q, mcand_q, mplier_q;
    logic [4:0]     iter_q;
    logic           cfs_q;
`endif

    assign dec    = decode(op_q);
    assign accept = req_valid && (state_q == IDLE);

    assign alu_ci = ctl.ci;
    assign alu_nb = ctl.nb;
    assign alu_ic = ctl.ic;
    assign alu_na = ctl.na;
    assign alu_xo = ctl.xo;
    assign alu_no = ctl.no;
    assign alu_sr = ctl.sr;
    assign alu_ss = ctl.ss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        state_d   = state_q;
        ctl       = '0;
        alu_a     = '0;
        alu_b     = '0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = EXEC;
`ifdef ALU_SEQ_MUL_EN
                    if (req_op == OP_MUL) state_d = MUL_ADD;
`endif
                end
            end
            EXEC: begin
                // Illegal opcodes occupy the EXEC slot with the ALU idle, keeping latency uniform.
                if (!err_q) begin
                    ctl   = dec.ctl;
                    alu_a = a_q;
                    case (dec.bsel)
                        B_ZERO:  alu_b = '0;
                        B_A:     alu_b = a_q;
                        default: alu_b = b_q;
                    endcase
                end
                state_d = RESP;
            end
`ifdef ALU_SEQ_MUL_EN
            MUL_ADD: begin
                alu_a   = acc_q;
                alu_b   = mcand_q;
                state_d = MUL_DBL;
            end
            MUL_DBL: begin
                alu_a   = mcand_q;
                alu_b   = mcand_q;
                state_d = (iter_q == 5'd15) ? RESP : MUL_ADD;
            end
`endif
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            err_q    <= 1'b0;
            rsp_data <= '0;
            rsp_cf   <= 1'b0;
            rsp_sf   <= 1'b0;
            rsp_zf   <= 1'b0;
            rsp_err  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            iter_q   <= '0;
            cfs_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples values from before the edge.
            if (accept) begin
                op_q  <= req_op;
                a_q   <= req_a;
                b_q   <= req_b;
                err_q <= !decode(req_op).legal;
`ifdef ALU_SEQ_MUL_EN
                acc_q    <= '0;
                mcand_q  <= req_a;
                mplier_q <= req_b;
                iter_q   <= '0;
                cfs_q    <= 1'b0;
`endif
            end
            case (state_q)
                EXEC: begin
                    rsp_data <= err_q ? '0 : alu_out;
                    rsp_cf   <= !err_q && alu_cf;
                    rsp_sf   <= !err_q && alu_sf;
                    rsp_zf   <= !err_q && alu_zf;
                    rsp_err  <= err_q;
                end
`ifdef ALU_SEQ_MUL_EN
                MUL_ADD: begin
                    if (mplier_q[0]) begin
                        acc_q <= alu_out;
                        cfs_q <= cfs_q | alu_cf;
                    end
                end
                MUL_DBL: begin
                    mcand_q  <= alu_out;
                    mplier_q <= mplier_q >> 1;
                    iter_q   <= iter_q + 5'd1;
                    if (iter_q == 5'd15) begin
                        rsp_data <= acc_q;
                        rsp_cf   <= cfs_q;
                        rsp_sf   <= acc_q[W-1];
                        rsp_zf   <= (acc_q == '0);
                        rsp_err  <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 16-bit ALU model on the ALU port.
// MUL checks run when ALU_SEQ_MUL_EN is defined; otherwise opcode 12 must be illegal.
module tb_alu_sequencer;
    localparam int W   = 16;
    localparam int OPW = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [OPW-1:0] req_op = '0;
    logic [W-1:0]   req_a = '0;
    logic [W-1:0]   req_b = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [W-1:0]   rsp_data;
    logic           rsp_cf, rsp_sf, rsp_zf, rsp_err;
    logic [W-1:0]   alu_a, alu_b;
    logic           alu_ci, alu_nb, alu_ic, alu_na, alu_xo, alu_no, alu_sr, alu_ss;
    logic [W-1:0]   alu_out;
    logic           alu_cf, alu_sf, alu_zf;

    int n_checks = 0;
    int n_pass   = 0;

    alu_sequencer #(.W(W), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_cf(rsp_cf), .rsp_sf(rsp_sf), .rsp_zf(rsp_zf), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_ci(alu_ci), .alu_nb(alu_nb), .alu_ic(alu_ic), .alu_na(alu_na),
        .alu_xo(alu_xo), .alu_no(alu_no), .alu_sr(alu_sr), .alu_ss(alu_ss),
        .alu_out(alu_out), .alu_cf(alu_cf), .alu_sf(alu_sf), .alu_zf(alu_zf)
    );

    always #5 clk = ~clk;

    // Combinational ALU: optional operand inversion, add or carry-inhibited xor/or,
    // optional right shift, optional output inversion.
    always_comb begin
        logic [W-1:0] aa, bb, r;
        logic         c;
        aa = alu_na ? ~alu_a : alu_a;
        bb = alu_nb ? ~alu_b : alu_b;
        r  = '0;
        c  = 1'b0;
        if (alu_ic) r = alu_xo ? (aa | bb) : (aa ^ bb);
        else        {c, r} = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, alu_ci};
        if (alu_sr) r = {alu_ss & r[W-1], r[W-1:1]};
        if (alu_no) r = ~r;
        alu_out = r;
        alu_cf  = c;
        alu_sf  = r[W-1];
        alu_zf  = (r == '0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    logic [7:0]   ctl_snap;
    logic [W-1:0] a_snap, b_snap;
    int           lat;

    // Issue one request, snapshot the EXEC-cycle ALU drive, and wait for rsp_valid.
    task automatic do_op(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        check("req_ready_before_issue", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        ctl_snap = {alu_ci, alu_nb, alu_ic, alu_na, alu_xo, alu_no, alu_sr, alu_ss};
        a_snap = alu_a;
        b_snap = alu_b;
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_after_handshake", 32'(rsp_valid), 32'd0);
    endtask

    typedef struct {
        logic [OPW-1:0] op;
        logic [W-1:0]   a, b;
        logic [W-1:0]   exp_b;
        logic [7:0]     exp_ctl;   // {ci,nb,ic,na,xo,no,sr,ss}
        logic [W-1:0]   exp_data;
        logic [2:0]     exp_flags; // {cf,sf,zf}
    } vec_t;

    vec_t vecs[14] = '{
        '{4'd0,  16'd9,      16'd8,      16'd8,      8'b00000000, 16'd17,     3'b000},
        '{4'd1,  16'd10,     16'd4,      16'd4,      8'b11000000, 16'd6,      3'b100},
        '{4'd1,  16'd4,      16'd10,     16'd10,     8'b11000000, 16'hFFFA,   3'b010},
        '{4'd2,  16'h00FF,   16'h0F0F,   16'h0F0F,   8'b00100000, 16'h0FF0,   3'b000},
        '{4'd3,  16'hFFFF,   16'h1234,   16'h0000,   8'b10000000, 16'h0000,   3'b101},
        '{4'd4,  16'h0000,   16'h1234,   16'h0000,   8'b01000000, 16'hFFFF,   3'b010},
        '{4'd5,  16'h00FF,   16'h5555,   16'h0000,   8'b01100000, 16'hFF00,   3'b010},
        '{4'd6,  16'h0001,   16'h0007,   16'h0000,   8'b10010000, 16'hFFFF,   3'b010},
        '{4'd7,  16'h00FF,   16'h0F0F,   16'h0F0F,   8'b00101000, 16'h0FFF,   3'b000},
        '{4'd8,  16'd10,     16'd9,      16'd9,      8'b01111100, 16'd8,      3'b000},
        '{4'd9,  16'h1234,   16'h00AA,   16'h1234,   8'b00000000, 16'h2468,   3'b000},
        '{4'd10, 16'h8001,   16'h00AA,   16'h0000,   8'b00000010, 16'h4000,   3'b000},
        '{4'd11, 16'hFFFC,   16'h00AA,   16'h0000,   8'b00000011, 16'hFFFE,   3'b010},
        '{4'd0,  16'd65534,  16'd2,      16'd2,      8'b00000000, 16'h0000,   3'b101}
    };

    initial begin
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_data",  32'(rsp_data),  32'd0);
        check("reset_rsp_err",   32'(rsp_err),   32'd0);
        check("reset_alu_drive", {8'd0, alu_a, alu_ci, alu_nb, alu_ic, alu_na,
                                  alu_xo, alu_no, alu_sr, alu_ss}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("op%0d_latency", vecs[i].op), 32'(lat), 32'd1);
            check($sformatf("op%0d_ctl", vecs[i].op), 32'(ctl_snap), 32'(vecs[i].exp_ctl));
            check($sformatf("op%0d_alu_ab", vecs[i].op), {a_snap, b_snap},
                  {vecs[i].a, vecs[i].exp_b});
            check($sformatf("op%0d_data", vecs[i].op), 32'(rsp_data), 32'(vecs[i].exp_data));
            check($sformatf("op%0d_flags_err", vecs[i].op), {28'd0, rsp_cf, rsp_sf, rsp_zf, rsp_err},
                  {28'd0, vecs[i].exp_flags, 1'b0});
            release_rsp();
        end

        // Illegal opcode: zero response, err set, ALU left idle.
        do_op(4'd14, 16'h1234, 16'h5678);
        check("illegal_latency", 32'(lat), 32'd1);
        check("illegal_ctl", 32'(ctl_snap), 32'd0);
        check("illegal_rsp", {11'd0, rsp_data, rsp_cf, rsp_sf, rsp_zf, rsp_err},
              {11'd0, 16'd0, 4'b0001});
        release_rsp();

        // Consumer stall: response must hold and a pending request must not be taken.
        do_op(4'd0, 16'd1, 16'd2);
        req_valid = 1'b1; req_op = 4'd1; req_a = 16'd5; req_b = 16'd1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("stall_hold", {12'd0, rsp_valid, req_ready, rsp_data, rsp_err, 1'b0},
                  {12'd0, 1'b1, 1'b0, 16'd3, 1'b0, 1'b0});
        end
        req_valid = 1'b0;
        release_rsp();
        check("stall_release_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        check("stall_no_extra_rsp", 32'(rsp_valid), 32'd0);

`ifdef ALU_SEQ_MUL_EN
        // 300*300: the 2^16 overflow is lost in a doubling, so no add carry is seen.
        do_op(4'd12, 16'd300, 16'd300);
        check("mul300_latency", 32'(lat), 32'd32);
        check("mul300_data", 32'(rsp_data), 32'd24464);
        check("mul300_flags_err", {28'd0, rsp_cf, rsp_sf, rsp_zf, rsp_err}, 32'd0);
        release_rsp();

        do_op(4'd12, 16'hFFFF, 16'd3);
        check("mulffff_latency", 32'(lat), 32'd32);
        check("mulffff_data", 32'(rsp_data), 32'h0000FFFD);
        check("mulffff_flags_err", {28'd0, rsp_cf, rsp_sf, rsp_zf, rsp_err}, 32'b1100);
        release_rsp();

        do_op(4'd12, 16'd7, 16'd0);
        check("mul7x0_latency", 32'(lat), 32'd32);
        check("mul7x0_data", 32'(rsp_data), 32'd0);
        check("mul7x0_flags_err", {28'd0, rsp_cf, rsp_sf, rsp_zf, rsp_err}, 32'b0010);
        release_rsp();

        // Reset in the middle of a multiply discards it without a response.
        req_valid = 1'b1; req_op = 4'd12; req_a = 16'd300; req_b = 16'd300;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mul_reset_idle", {29'd0, req_ready, rsp_valid, (alu_a != '0)}, 32'b100);
        @(negedge clk); rst_n = 1'b1;
        begin
            int seen = 0;
            repeat (40) begin
                @(posedge clk); #1;
                if (rsp_valid) seen++;
            end
            check("mul_reset_no_rsp", 32'(seen), 32'd0);
        end
        do_op(4'd0, 16'd2, 16'd3);
        check("post_reset_add", {15'd0, rsp_data, rsp_err}, {15'd0, 16'd5, 1'b0});
        release_rsp();
`else
        do_op(4'd12, 16'd300, 16'd300);
        check("op12_illegal_latency", 32'(lat), 32'd1);
        check("op12_illegal_rsp", {11'd0, rsp_data, rsp_cf, rsp_sf, rsp_zf, rsp_err},
              {11'd0, 16'd0, 4'b0001});
        release_rsp();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
